jk_excite_ctrl: RTL and testbench

Drive-side controller for a bank of W JK flip-flops clocked on the same clk and reset by the same rst.
- Accepts target register values over a valid/ready handshake.
- Computes per-bit J/K excitation from the fed-back Q and the target, drives it for exactly one cycle, then checks that the bank landed on the target.
- Inverse of the JK cell: it maps "desired next state" to J/K inputs. Used wherever the design loads JK-based state registers.

---
 rtl/jk_excite_ctrl.sv | 121 ++++++++++++
 tb/tb_jk_excite_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_ctrl.sv
// Drive-side controller for a bank of W JK flip-flops: converts a target word into
// one cycle of J/K excitation, then verifies the bank landed on the target.
module jk_excite_ctrl #(
    parameter int W             = 8,
    parameter bit PREFER_TOGGLE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] q_fb,
    output logic [W-1:0] j_out,
    output logic [W-1:0] k_out,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic         clr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic [W-1:0]   tgt_r, tgt_s;
    logic [W-1:0]   j_r, j_s;
    logic [W-1:0]   k_r, k_s;
    logic           done_r, done_s;
    logic           err_r, err_s;
    logic           xfer_s;

    // Inverse JK map: returns {j, k} that moves q to t in one edge.
    function automatic logic [2*W-1:0] excite(input logic [W-1:0] q, input logic [W-1:0] t);
        logic [W-1:0] j;
        logic [W-1:0] k;
        if (PREFER_TOGGLE) begin
            j = q ^ t;
            k = q ^ t;
        end else begin
            j = ~q & t;
            k = q & ~t;
        end
        return {j, k};
    endfunction

    assign in_ready = (state_r == IDLE) && !rst;
    assign xfer_s   = in_valid && in_ready;
    assign busy     = (state_r != IDLE);
    assign j_out    = j_r;
    assign k_out    = k_r;
    assign done     = done_r;
    assign err      = err_r;

    // Next-state and next-output logic; excitation is nonzero only entering DRIVE.
    always_comb begin
        state_s = state_r;
        tgt_s   = tgt_r;
        j_s     = {W{1'b0}};
        k_s     = {W{1'b0}};
        done_s  = 1'b0;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    tgt_s      = in_data;
                    {j_s, k_s} = excite(q_fb, in_data);
                    state_s    = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                state_s = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_r) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    err_s   = 1'b1;
                    state_s = ERROR;
                end
            end
            ERROR: begin
                if (clr_err) begin
                    err_s   = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = ERROR;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            tgt_r   <= {W{1'b0}};
            j_r     <= {W{1'b0}};
            k_r     <= {W{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            tgt_r   <= tgt_s;
            j_r     <= j_s;
            k_r     <= k_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Scoreboard bench for jk_excite_ctrl: two instances (set/reset and toggle styles)
// share stimulus, each driving its own behavioural JK bank with optional stuck-at-0 bits.
module tb_jk_excite_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       clr_err;
    logic [7:0] stuck;

    logic       rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
    logic [7:0] j0, k0, j1, k1, q0, q1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] j0, k0, j1, k1, tgt;
        logic       ok;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] sh;

    always #5 clk = ~clk;

    jk_excite_ctrl #(.W(8), .PREFER_TOGGLE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .q_fb(q0), .j_out(j0), .k_out(k0), .busy(busy0), .done(done0), .err(err0),
        .clr_err(clr_err)
    );

    jk_excite_ctrl #(.W(8), .PREFER_TOGGLE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .q_fb(q1), .j_out(j1), .k_out(k1), .busy(busy1), .done(done1), .err(err1),
        .clr_err(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
        end
    endtask

    // Behavioural JK banks: Q+ = J~Q | ~K Q, with stuck-at-0 bits forced low.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0 <= 8'h00;
            q1 <= 8'h00;
        end else begin
            q0 <= ((j0 & ~q0) | (~k0 & q0)) & ~stuck;
            q1 <= ((j1 & ~q1) | (~k1 & q1)) & ~stuck;
        end
    end

    // Scoreboard push on every accepted word; reset discards pending targets.
    always @(posedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            sh <= 3'b000;
            sb.delete();
        end else begin
            sh <= {sh[1:0], in_valid && rdy0};
            if (in_valid && rdy0) begin
                e.tgt = in_data;
                e.j0  = ~q0 & in_data;
                e.k0  = q0 & ~in_data;
                e.j1  = q1 ^ in_data;
                e.k1  = q1 ^ in_data;
                e.ok  = ((in_data & stuck) == 8'h00);
                sb.push_back(e);
            end
        end
    end

    // Compare phase-by-phase after each transfer: DRIVE, CHECK, then the done cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sh[0]) begin
            if (sb.size() == 0) begin
                chk("sb_drive_empty", 32'd0, 32'd1);
            end else begin
                e = sb[$];
                chk("drive_j0", j0, e.j0);
                chk("drive_k0", k0, e.k0);
                chk("drive_j1", j1, e.j1);
                chk("drive_k1", k1, e.k1);
                chk("drive_busy", busy0, 1'b1);
            end
        end
        if (sh[1]) begin
            chk("check_jk0", {j0, k0}, 16'h0000);
            chk("check_jk1", {j1, k1}, 16'h0000);
        end
        if (sh[2]) begin
            if (sb.size() == 0) begin
                chk("sb_done_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("done0", done0, e.ok);
                chk("done1", done1, e.ok);
                chk("err0", err0, !e.ok);
                chk("err1", err1, !e.ok);
                if (e.ok) begin
                    chk("bank0", q0, e.tgt);
                    chk("bank1", q1, e.tgt);
                end
            end
        end else begin
            chk("done_quiet", {done0, done1}, 2'b00);
        end
    end

    task automatic send(input logic [7:0] d);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!rdy0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rdy_wait", rdy0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int xc[2];
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clr_err  = 1'b0;
        stuck    = 8'h00;

        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", {rdy0, rdy1}, 2'b00);
            chk("rst_jk", {j0, k0, j1, k1}, 32'h0);
            chk("rst_flags", {done0, err0, busy0, busy1}, 4'b0000);
        end
        rst = 1'b0;
        #1;
        chk("rel_ready", {rdy0, rdy1}, 2'b11);
        chk("rel_busy", busy0, 1'b0);

        @(negedge clk);
        send(8'hA5);
        chk("a5_j0", j0, 8'hA5);
        chk("a5_k0", k0, 8'h00);
        repeat (3) @(negedge clk);

        send(8'h3C);
        chk("3c_j0", j0, 8'h18);
        chk("3c_k0", k0, 8'h81);
        chk("3c_jk1", {j1, k1}, 16'h9999);
        @(negedge clk);
        chk("3c_q0", q0, 8'h3C);
        chk("3c_q1", q1, 8'h3C);
        repeat (2) @(negedge clk);

        send(8'h3C);
        chk("same_jk", {j0, k0, j1, k1}, 32'h0);
        repeat (3) @(negedge clk);

        // Bit 0 stuck low: target 0x01 can never be reached.
        stuck = 8'h01;
        send(8'h01);
        repeat (2) @(negedge clk);
        chk("flt_err", {err0, err1}, 2'b11);
        chk("flt_ready", rdy0, 1'b0);
        chk("flt_busy", busy0, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            chk("flt_block", {rdy0, rdy1}, 2'b00);
            chk("flt_sticky", err0, 1'b1);
        end
        in_valid = 1'b0;
        clr_err  = 1'b1;
        @(negedge clk);
        clr_err  = 1'b0;
        stuck    = 8'h00;
        chk("clr_err", {err0, err1}, 2'b00);
        chk("clr_ready", {rdy0, rdy1}, 2'b11);
        @(negedge clk);

        // Back-to-back with in_valid held: transfers 3 cycles apart.
        n        = 0;
        xc[0]    = 0;
        xc[1]    = 0;
        in_valid = 1'b1;
        in_data  = 8'h11;
        for (int c = 0; c < 15 && n < 2; c++) begin
            if (rdy0) begin
                xc[n] = c;
                if (n == 1) chk("done_with_xfer", done0, 1'b1);
                n++;
            end
            @(negedge clk);
            if (n == 1) in_data = 8'h22;
        end
        in_valid = 1'b0;
        chk("b2b_count", n, 2);
        chk("b2b_gap", xc[1] - xc[0], 3);
        repeat (3) @(negedge clk);
        chk("b2b_bank", q0, 8'h22);

        // Reset during DRIVE.
        send(8'h7E);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_jk", {j0, k0, j1, k1}, 32'h0);
        chk("rst_mid_ready", rdy0, 1'b0);
        chk("rst_mid_busy", busy0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_flags", {done0, err0, done1, err1}, 4'b0000);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", rdy0, 1'b1);
        chk("post_rst_bank", q0, 8'h00);

        send(8'h5A);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
